// File: rtl/axis_write_sched_pkg.sv
// Shared config-bus definitions for the AXI-stream writer and its job scheduler:
// default config words and the one-hot FSM state layout.
package axis_write_sched_pkg;

  localparam int unsigned CfgIdDefault     = 1;
  localparam int unsigned CfgAddrDefault   = 23;
  localparam int unsigned CfgDataDefault   = 24;
  localparam int unsigned CfgAwidthDefault = 5;
  localparam int unsigned CfgDwidthDefault = 32;

  localparam int unsigned StIdleBit     = 0;
  localparam int unsigned StSendIdBit   = 1;
  localparam int unsigned StSendAddrBit = 2;
  localparam int unsigned StSendLenBit  = 3;
  localparam int unsigned StStreamBit   = 4;
  localparam int unsigned StDoneBit     = 5;
  localparam int unsigned NumStates     = 6;

  typedef enum logic [NumStates-1:0] {
    StIdle     = NumStates'(1 << StIdleBit),
    StSendId   = NumStates'(1 << StSendIdBit),
    StSendAddr = NumStates'(1 << StSendAddrBit),
    StSendLen  = NumStates'(1 << StSendLenBit),
    StStream   = NumStates'(1 << StStreamBit),
    StDone     = NumStates'(1 << StDoneBit)
  } state_e;

  // Round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned sel, input int unsigned n);
    return (sel + 1 == n) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/axis_rr_arb.sv
// Round-robin arbiter: picks the first active request at or after a rotating
// pointer; the pointer moves past the winner when the caller strobes advance.
module axis_rr_arb
  import axis_write_sched_pkg::*;
#(
  parameter int unsigned NB_REQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB_REQ-1:0] req,
  input  logic              advance,
  output logic [NB_REQ-1:0] grant,
  output logic              any
);

  localparam int unsigned PtrW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx, sel;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    sel   = ptr_q;
    idx   = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % NB_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        sel        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign ptr_d = (advance && any) ? PtrW'(rr_next(32'(sel), NB_REQ)) : ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axis_write_sched.sv
// Shares one stream writer among NB_REQ requesters: accepts one job at a time,
// programs the writer over the config bus, then watches the stream to completion.
module axis_write_sched
  import axis_write_sched_pkg::*;
#(
  parameter int unsigned NB_REQ        = 2,
  parameter int unsigned CONFIG_ID     = CfgIdDefault,
  parameter int unsigned CONFIG_ADDR   = CfgAddrDefault,
  parameter int unsigned CONFIG_DATA   = CfgDataDefault,
  parameter int unsigned CONFIG_AWIDTH = CfgAwidthDefault,
  parameter int unsigned CONFIG_DWIDTH = CfgDwidthDefault
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NB_REQ-1:0]                 req_valid,
  input  logic [NB_REQ*CONFIG_DWIDTH-1:0]   req_address,
  input  logic [NB_REQ*CONFIG_DWIDTH-1:0]   req_length,
  output logic [NB_REQ-1:0]                 req_ready,
  output logic [NB_REQ-1:0]                 req_done,
  output logic [CONFIG_AWIDTH-1:0]          cfg_addr,
  output logic [CONFIG_DWIDTH-1:0]          cfg_data,
  output logic                              cfg_valid,
  input  logic                              str_valid,
  input  logic                              str_ready,
  output logic [NB_REQ-1:0]                 grant,
  output logic                              busy
);

  state_e state_q, state_d;

  logic [CONFIG_DWIDTH-1:0] addr_q, addr_d;
  logic [CONFIG_DWIDTH-1:0] len_q, len_d;
  logic [CONFIG_DWIDTH-1:0] cnt_q, cnt_d;
  logic [CONFIG_DWIDTH-1:0] sel_addr, sel_len;
  logic [CONFIG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
  logic [CONFIG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic                     cfg_valid_q, cfg_valid_d;
  logic [NB_REQ-1:0]        grant_q, grant_d;
  logic [NB_REQ-1:0]        arb_grant;
  logic                     arb_any;
  logic                     accept;
  logic                     beat;
  logic                     len_reached;

  axis_rr_arb #(
    .NB_REQ (NB_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (arb_grant),
    .any     (arb_any)
  );

  assign beat   = str_valid & str_ready;
  assign accept = (state_q == StIdle) & arb_any;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr = req_address[i*CONFIG_DWIDTH +: CONFIG_DWIDTH];
        sel_len  = req_length[i*CONFIG_DWIDTH +: CONFIG_DWIDTH];
      end
    end
  end

  // Beats may already have arrived while the config words were going out.
  assign len_reached = (cnt_q >= len_q) || (beat && (cnt_q == len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          addr_d  = sel_addr;
          len_d   = sel_len;
          cnt_d   = '0;
          grant_d = arb_grant;
          state_d = (sel_len == '0) ? StDone : StSendId;
        end
      end
      StSendId: begin
        cnt_d   = cnt_q + CONFIG_DWIDTH'(beat);
        state_d = StSendAddr;
      end
      StSendAddr: begin
        cnt_d   = cnt_q + CONFIG_DWIDTH'(beat);
        state_d = StSendLen;
      end
      StSendLen: begin
        cnt_d   = cnt_q + CONFIG_DWIDTH'(beat);
        state_d = len_reached ? StDone : StStream;
      end
      StStream: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Config words are registered against the state they belong to.
  always_comb begin
    cfg_valid_d = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    unique case (state_d)
      StSendId: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_ADDR);
        cfg_data_d  = CONFIG_DWIDTH'(CONFIG_ID);
      end
      StSendAddr: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
        cfg_data_d  = addr_q;
      end
      StSendLen: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
        cfg_data_d  = len_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  // The accept strobe is combinational, so hold it quiet while in reset.
  assign req_ready = (accept && rst) ? arb_grant : '0;
  assign req_done  = (state_q == StDone) ? grant_q : '0;
  assign grant     = grant_q;
  assign busy      = (state_q != StIdle);
  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;

endmodule

// File: tb/tb_axis_write_sched.sv
// Directed bench for axis_write_sched with a job-level reference model checked
// every cycle plus literal expectations for each scenario.
module tb_axis_write_sched;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_address;
  logic [N*DW-1:0] req_length;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_done;
  logic [AW-1:0]   cfg_addr;
  logic [DW-1:0]   cfg_data;
  logic            cfg_valid;
  logic            str_valid;
  logic            str_ready;
  logic [N-1:0]    grant;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  axis_write_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_address (req_address),
    .req_length  (req_length),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .str_valid   (str_valid),
    .str_ready   (str_ready),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Job-level model: a job starts on the pick cycle, config words sit at offsets
  // 1..3, and completion is the first offset >= 4 whose earlier beats cover the length.
  bit          m_active = 1'b0;
  int          m_off, m_sel, m_ptr = 0;
  logic [31:0] m_addr, m_len;
  longint      m_beats;
  logic [4:0]  m_caddr = '0;
  logic [31:0] m_cdata = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_done, e_grant;
    logic         e_valid, e_busy;
    int           pick;
    bit           fin;
    e_ready = '0; e_done = '0; e_grant = '0; e_valid = 1'b0; e_busy = 1'b0; fin = 1'b0;
    if (!rst) begin
      m_active = 1'b0; m_ptr = 0; m_caddr = '0; m_cdata = '0;
    end else if (!m_active) begin
      pick = -1;
      for (int i = 0; i < N; i++)
        if (pick < 0 && req_valid[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
      if (pick >= 0) begin
        e_ready[pick] = 1'b1;
        m_active = 1'b1; m_off = 0; m_sel = pick; m_beats = 0; m_ptr = (pick + 1) % N;
        m_addr = req_address[pick*DW +: DW];
        m_len  = req_length[pick*DW +: DW];
      end
    end else begin
      m_off++;
      e_busy = 1'b1;
      e_grant[m_sel] = 1'b1;
      if (m_len == 0) fin = (m_off == 1);
      else fin = (m_off >= 4) && (m_beats >= longint'(m_len));
      if (fin) e_done[m_sel] = 1'b1;
      if (m_len != 0 && m_off <= 3) begin
        e_valid = 1'b1;
        m_caddr = (m_off == 1) ? 5'd23 : 5'd24;
        m_cdata = (m_off == 1) ? 32'd1 : (m_off == 2) ? m_addr : m_len;
      end
      if (str_valid && str_ready) m_beats++;
      if (fin) m_active = 1'b0;
    end
    chk("model_req_ready", req_ready, e_ready);
    chk("model_req_done", req_done, e_done);
    chk("model_grant", grant, e_grant);
    chk("model_busy", busy, e_busy);
    chk("model_cfg_valid", cfg_valid, e_valid);
    chk("model_cfg_addr", cfg_addr, m_caddr);
    chk("model_cfg_data", cfg_data, m_cdata);
  end

  task automatic set_job(input int i, input logic [31:0] a, input logic [31:0] l);
    req_address[i*DW +: DW] = a;
    req_length[i*DW +: DW]  = l;
  endtask

  // Bounded wait for req_ready[i] (is_done=0) or req_done[i] (is_done=1).
  task automatic wait_for(input bit is_done, input int i, input string nm);
    int n = 0;
    @(negedge clk);
    while (((is_done ? req_done[i] : req_ready[i]) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, is_done ? req_done[i] : req_ready[i], 1);
  endtask

  initial begin
    bit [4:0] pat = 5'b10101;
    rst = 1'b0; req_valid = '0; req_address = '0; req_length = '0;
    str_valid = 1'b0; str_ready = 1'b0;

    // Contention: both requesters valid out of reset
    set_job(0, 32'h100, 1); set_job(1, 32'h200, 2);
    req_valid = 2'b11; str_valid = 1'b1; str_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cfg_data", cfg_data, 0);
    @(posedge clk); #1; rst = 1'b1;
    wait_for(0, 0, "cont_first_req0");
    chk("cont_first_onehot", req_ready, 2'b01);
    wait_for(0, 1, "cont_then_req1");
    chk("cont_second_onehot", req_ready, 2'b10);
    wait_for(0, 0, "cont_again_req0");
    @(posedge clk); #1; req_valid = '0;
    wait_for(1, 0, "cont_done0");

    // Single job, len 4, beats only in STREAM
    @(posedge clk); #1; str_valid = 1'b0; str_ready = 1'b0;
    set_job(0, 32'h1000, 4); req_valid = 2'b01;
    wait_for(0, 0, "single_ready");
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    chk("single_w1_valid", cfg_valid, 1); chk("single_w1_addr", cfg_addr, 23);
    chk("single_w1_data", cfg_data, 1);
    @(negedge clk);
    chk("single_w2_addr", cfg_addr, 24); chk("single_w2_data", cfg_data, 32'h1000);
    @(negedge clk);
    chk("single_w3_addr", cfg_addr, 24); chk("single_w3_data", cfg_data, 4);
    @(posedge clk); #1; str_valid = 1'b1; str_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("single_no_early_done", req_done, 0);
    end
    @(posedge clk); #1; str_valid = 1'b0; str_ready = 1'b0;
    @(negedge clk);
    chk("single_done", req_done, 2'b01);
    chk("single_cfg_hold", cfg_data, 4);

    // Zero length on requester 1
    @(posedge clk); #1; set_job(1, 32'h3000, 0); req_valid = 2'b10;
    @(negedge clk);
    chk("zero_ready", req_ready, 2'b10); chk("zero_busy_idle", busy, 0);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    chk("zero_done", req_done, 2'b10); chk("zero_no_cfg", cfg_valid, 0);
    @(negedge clk);
    chk("zero_back_idle", busy, 0);

    // Early beats during SEND_ADDR / SEND_LEN
    @(posedge clk); #1; set_job(0, 32'h2000, 2); req_valid = 2'b01;
    @(negedge clk); chk("early_ready", req_ready, 2'b01);
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1; str_valid = 1'b1; str_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("early_len_word", cfg_data, 2);
    @(posedge clk); #1; str_valid = 1'b0; str_ready = 1'b0;
    @(negedge clk);
    chk("early_done", req_done, 2'b01); chk("early_cfg_off", cfg_valid, 0);

    // Backpressure, len 3, ready 1-0-1-0-1
    @(posedge clk); #1; set_job(0, 32'h4000, 3); req_valid = 2'b01;
    @(negedge clk); chk("bp_ready", req_ready, 2'b01);
    @(posedge clk); #1; req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; str_valid = 1'b1; str_ready = pat[4-k];
      @(negedge clk);
      chk("bp_busy", busy, 1); chk("bp_not_done", req_done, 0);
    end
    @(posedge clk); #1; str_valid = 1'b0; str_ready = 1'b0;
    @(negedge clk); chk("bp_done", req_done, 2'b01);

    // Reset mid-STREAM after 2 of 8 beats; pointer sits at 1 beforehand
    @(posedge clk); #1; set_job(0, 32'h5000, 8); req_valid = 2'b01;
    @(negedge clk); chk("rst_job_ready", req_ready, 2'b01);
    @(posedge clk); #1; req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1; str_valid = 1'b1; str_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; str_valid = 1'b0; str_ready = 1'b0;
    set_job(0, 32'h6000, 1); set_job(1, 32'h7000, 1); req_valid = 2'b11;
    #1;
    chk("midrst_busy", busy, 0); chk("midrst_grant", grant, 0);
    chk("midrst_cfg_valid", cfg_valid, 0); chk("midrst_cfg_addr", cfg_addr, 0);
    chk("midrst_cfg_data", cfg_data, 0); chk("midrst_req_ready", req_ready, 0);
    chk("midrst_req_done", req_done, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); chk("post_rst_ptr0", req_ready, 2'b01);
    @(posedge clk); #1; req_valid = '0; str_valid = 1'b1; str_ready = 1'b1;
    wait_for(1, 0, "post_rst_done");
    @(posedge clk); #1; str_valid = 1'b0; str_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
